// File: rtl/rr_mux_4_1_arbiter.sv
// rr_mux_4_1_arbiter: four-requester round-robin packet multiplexer with a
// single registered output stage. Once a multi-beat packet wins, the
// arbiter stays locked on that requester until its last beat is accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   [3:0] requester i offers a beat
//   in_last    [3:0] requester i's beat closes its packet
//   d0..d3     [W-1:0] requester data
//   in_ready   [3:0] one-hot (or zero) accept, combinational
//   out_valid  output register holds a beat
//   out_ready  downstream accepts the held beat
//   y          [W-1:0] held beat data
//   out_last   held beat's last flag
//   out_sel    [1:0] requester index of the held beat
module rr_mux_4_1_arbiter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    input  logic [3:0]   in_last,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [3:0]   in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         out_last,
    output logic [1:0]   out_sel
);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   owner;
    logic [1:0]   ptr;
    logic         load_en;
    logic         xfer;
    logic [1:0]   xfer_idx;
    logic         xfer_last;
    logic [W-1:0] xfer_data;

    // The output register can take a new beat when empty or being drained.
    assign load_en = !out_valid | out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: lock on a non-final beat, unlock on the owner's final beat.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB: begin
                if (xfer && !xfer_last) begin
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                if (xfer && xfer_last) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // Output: grant generation; rotating search starts just after ptr.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        in_ready = 4'b0000;
        found    = 1'b0;
        cand     = 2'd0;
        if (!rst && load_en) begin
            if (state == LOCK) begin
                in_ready[owner] = 1'b1;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    cand = ptr + 2'(k);
                    if (!found && in_valid[cand]) begin
                        found          = 1'b1;
                        in_ready[cand] = 1'b1;
                    end
                end
            end
        end
    end

    // Accepted beat: in_ready is one-hot, so encode it directly.
    always_comb begin
        xfer     = |(in_valid & in_ready);
        xfer_idx = 2'd0;
        case (in_ready)
            4'b0010: xfer_idx = 2'd1;
            4'b0100: xfer_idx = 2'd2;
            4'b1000: xfer_idx = 2'd3;
            default: xfer_idx = 2'd0;
        endcase
        xfer_last = in_last[xfer_idx];
        case (xfer_idx)
            2'd0:    xfer_data = d0;
            2'd1:    xfer_data = d1;
            2'd2:    xfer_data = d2;
            default: xfer_data = d3;
        endcase
    end

    // Output register, pointer and owner; a new beat replaces a drained one.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 2'd3;
            owner     <= 2'd0;
            out_valid <= 1'b0;
            y         <= '0;
            out_last  <= 1'b0;
            out_sel   <= 2'd0;
        end else if (xfer) begin
            ptr       <= xfer_idx;
            owner     <= xfer_idx;
            out_valid <= 1'b1;
            y         <= xfer_data;
            out_last  <= xfer_last;
            out_sel   <= xfer_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_4_1_arbiter.sv
// tb_rr_mux_4_1_arbiter: directed scenarios plus random traffic, every cycle
// compared against a packet-level reference model of the arbiter.
module tb_rr_mux_4_1_arbiter;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [3:0]   in_last;
    logic [W-1:0] d [4];
    logic [3:0]   in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         out_last;
    logic [1:0]   out_sel;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state.
    bit         m_locked;
    int         m_owner;
    int         m_ptr;
    bit         m_valid;
    int         m_y;
    bit         m_last;
    int         m_sel;
    logic [3:0] m_ready;

    always #5 clk = ~clk;

    rr_mux_4_1_arbiter #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .d0        (d[0]),
        .d1        (d[1]),
        .d2        (d[2]),
        .d3        (d[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_last  (out_last),
        .out_sel   (out_sel)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Which requester may transfer this cycle, from the rules alone.
    function automatic logic [3:0] model_ready();
        logic [3:0] r = 4'b0000;
        if (rst || !(!m_valid || out_ready)) return r;
        if (m_locked) begin
            r[m_owner] = 1'b1;
            return r;
        end
        for (int k = 1; k <= 4; k++) begin
            int idx = (m_ptr + k) % 4;
            if (in_valid[idx]) begin
                r[idx] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_update();
        int  win = -1;
        if (rst) begin
            m_locked = 0; m_owner = 0; m_ptr = 3;
            m_valid = 0; m_y = 0; m_last = 0; m_sel = 0;
            return;
        end
        for (int i = 0; i < 4; i++)
            if (in_valid[i] && m_ready[i]) win = i;
        if (win >= 0) begin
            m_y     = int'(d[win]);
            m_last  = in_last[win];
            m_sel   = win;
            m_valid = 1;
            m_ptr   = win;
            m_owner = win;
            m_locked = !in_last[win];
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    endtask

    // One cycle: drive at negedge, check before the edge, advance model at it.
    task automatic cycle(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic ordy, input bit chk, input logic [3:0] want);
        rst       = r;
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        for (int i = 0; i < 4; i++) d[i] = W'($urandom);
        #1;
        m_ready = model_ready();
        check("in_ready", 32'(in_ready), 32'(m_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("y", 32'(y), 32'(m_y));
            check("out_last", 32'(out_last), 32'(m_last));
            check("out_sel", 32'(out_sel), 32'(m_sel));
        end
        if (chk) check("in_ready_dir", 32'(in_ready), 32'(want));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = '0;
        m_ptr = 3;
        @(negedge clk);
        cycle(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000);
        cycle(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000);
        // Reset values of the registered outputs.
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);

        // Full-throughput rotation over all four single-beat requesters.
        for (int c = 0; c < 8; c++)
            cycle(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'(1 << (c % 4)));

        // Skip from ptr = 0 over requester 1 to 2, then wrap to 0.
        cycle(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000);
        cycle(1'b0, 4'b0001, 4'b1111, 1'b1, 1'b1, 4'b0001);
        cycle(1'b0, 4'b0101, 4'b1111, 1'b1, 1'b1, 4'b0100);
        cycle(1'b0, 4'b0101, 4'b1111, 1'b1, 1'b1, 4'b0001);

        // Requester 1 holds the lock for a three-beat packet, then 2 wins.
        cycle(1'b0, 4'b1111, 4'b1101, 1'b1, 1'b1, 4'b0010);
        cycle(1'b0, 4'b1111, 4'b1101, 1'b1, 1'b1, 4'b0010);
        cycle(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010);
        cycle(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0100);

        // Backpressure: output stalls, then drains with a same-cycle grant.
        for (int c = 0; c < 3; c++)
            cycle(1'b0, 4'b0001, 4'b1111, 1'b0, 1'b1, 4'b0000);
        cycle(1'b0, 4'b0001, 4'b1111, 1'b1, 1'b1, 4'b0001);

        // Reset in the middle of a locked packet.
        cycle(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010);
        cycle(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0000);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        cycle(1'b0, 4'b1000, 4'b1111, 1'b1, 1'b1, 4'b1000);

        // Random traffic with occasional resets and mixed packet lengths.
        for (int c = 0; c < 400; c++)
            cycle(($urandom_range(0, 49) == 0), 4'($urandom), 4'($urandom | $urandom),
                  ($urandom_range(0, 3) != 0), 1'b0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
